// File: rtl/disp_scan_ctrl_pkg.sv
// disp_scan_ctrl_pkg: segment codes, conversion FSM states and digit decode for the display scanner
package disp_scan_ctrl_pkg;
   localparam int DIG_N = 4;
   localparam logic [7:0] SEG_0   = 8'hC0;
   localparam logic [7:0] SEG_1   = 8'hF9;
   localparam logic [7:0] SEG_2   = 8'hA4;
   localparam logic [7:0] SEG_3   = 8'hB0;
   localparam logic [7:0] SEG_4   = 8'h99;
   localparam logic [7:0] SEG_5   = 8'h92;
   localparam logic [7:0] SEG_6   = 8'h82;
   localparam logic [7:0] SEG_7   = 8'hF8;
   localparam logic [7:0] SEG_8   = 8'h80;
   localparam logic [7:0] SEG_9   = 8'h90;
   localparam logic [7:0] SEG_OFF = 8'hFF;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;
   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0: return SEG_0;
         4'd1: return SEG_1;
         4'd2: return SEG_2;
         4'd3: return SEG_3;
         4'd4: return SEG_4;
         4'd5: return SEG_5;
         4'd6: return SEG_6;
         4'd7: return SEG_7;
         4'd8: return SEG_8;
         4'd9: return SEG_9;
         default: return SEG_OFF;
      endcase
   endfunction
endpackage

// File: rtl/disp_scan_ctrl_bin2bcd_seq.sv
// bin2bcd_seq: 10-bit binary to 4-digit BCD, one shift-add-3 step per cycle; done marks the last step
module bin2bcd_seq (
   input  logic        clkm,
   input  logic        rst_n,
   input  logic        start,
   input  logic [9:0]  bin,
   output logic        done,
   output logic [15:0] bcd
);
   logic [25:0] sr_q, sr_d, ad;
   logic [3:0]  cnt_q, cnt_d;
   logic        run_q, run_d;
   always_comb begin
      ad = sr_q;
      for (int i = 0; i < 4; i++)
         ad[10+4*i +: 4] = sr_q[10+4*i +: 4] >= 4'd5 ? sr_q[10+4*i +: 4] + 4'd3 : sr_q[10+4*i +: 4];
      sr_d  = start ? {16'b0, bin} : run_q ? ad << 1 : sr_q;
      cnt_d = start ? 4'd0 : run_q ? cnt_q + 4'd1 : cnt_q;
      run_d = start || (run_q && cnt_q != 4'd9);
   end
   always_ff @(posedge clkm or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end
   assign done = run_q && cnt_q == 4'd9;
   assign bcd  = sr_q[25:10];
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: converts datodis to BCD on change and scans 4 digits; DISP_LZB_EN adds leading-zero blanking
module disp_scan_ctrl
   import disp_scan_ctrl_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int SCAN_W   = 16
) (
   input  logic       clkm,
   input  logic       rst_n,
   input  logic [9:0] datodis,
   output logic [3:0] an,
   output logic [7:0] seg,
   output logic       busy,
   output logic       upd
);
   state_t             state_q, state_d;
   logic [9:0]         snap_q, snap_d;
   logic [4*DIG_N-1:0] dig_q, dig_d;
   logic [SCAN_W-1:0]  pre_q, pre_d;
   logic [1:0]         idx_q, idx_d;
   logic               valid_q, valid_d, upd_q, upd_d, busy_q, busy_d, ghost_q, ghost_d;
   logic               tick, start, done, blank;
   logic [15:0]        bcd;
   logic [3:0]         cur;
   assign start = state_q == LOAD;
   bin2bcd_seq u_bcd (.clkm(clkm), .rst_n(rst_n), .start(start), .bin(datodis), .done(done), .bcd(bcd));
   always_comb begin
      state_d = state_q == IDLE  ? ((!valid_q || datodis != snap_q) ? LOAD : IDLE) :
                state_q == LOAD  ? SHIFT :
                state_q == SHIFT ? (done ? COMMIT : SHIFT) : IDLE;
      snap_d  = start ? datodis : snap_q;
      dig_d   = state_q == COMMIT ? bcd : dig_q;
      valid_d = valid_q || state_q == COMMIT;
      upd_d   = state_d == COMMIT;
      busy_d  = state_d == LOAD || state_d == SHIFT;
      tick    = pre_q == SCAN_W'(SCAN_DIV - 1);
      pre_d   = tick ? '0 : pre_q + 1'b1;
      idx_d   = idx_q + {1'b0, tick};
      ghost_d = tick;
   end
   // ghost starts set so the display stays dark while in reset
   always_ff @(posedge clkm or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         snap_q  <= '0;
         dig_q   <= '0;
         valid_q <= 1'b0;
         upd_q   <= 1'b0;
         busy_q  <= 1'b0;
         pre_q   <= '0;
         idx_q   <= '0;
         ghost_q <= 1'b1;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         dig_q   <= dig_d;
         valid_q <= valid_d;
         upd_q   <= upd_d;
         busy_q  <= busy_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         ghost_q <= ghost_d;
      end
   end
   assign cur = dig_q[4*idx_q +: 4];
`ifdef DISP_LZB_EN
   assign blank = (idx_q == 2'd3 && dig_q[15:12] == 4'd0) ||
                  (idx_q == 2'd2 && dig_q[15:8] == 8'd0) ||
                  (idx_q == 2'd1 && dig_q[15:4] == 12'd0);
`else
   assign blank = 1'b0;
`endif
   assign an   = ghost_q ? 4'hF : ~(4'b0001 << idx_q);
   assign seg  = (ghost_q || blank) ? SEG_OFF : seg_decode(cur);
   assign busy = busy_q;
   assign upd  = upd_q;
endmodule
